// File: rtl/soc_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : soc_uart_tx_if
//  Brief    : Simple SoC data-bus bundle between a bus master (CPU side)
//             and the soc_uart_tx register target.
//  Revision : 1.0  initial release
// ============================================================================
interface soc_uart_tx_if;
    logic        BusEn;
    logic        BusWe;
    logic [1:0]  BusAddr;
    logic [31:0] BusWData;
    logic [31:0] BusRData;
    logic        BusAck;

    modport master (
        output BusEn,
        output BusWe,
        output BusAddr,
        output BusWData,
        input  BusRData,
        input  BusAck
    );

    modport slave (
        input  BusEn,
        input  BusWe,
        input  BusAddr,
        input  BusWData,
        output BusRData,
        output BusAck
    );
endinterface
`default_nettype wire

// File: rtl/soc_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : soc_uart_tx
//  Brief    : Memory-mapped 8N1 UART transmitter. CPU writes bytes into a
//             small TX FIFO; a shifter sends them on TxD with a programmable
//             baud divisor (bit period = BAUDDIV+1 clocks).
//             Registers: 0 TXDATA, 1 STATUS, 2 BAUDDIV, 3 reserved.
//  Revision : 1.0  initial release
// ============================================================================
module soc_uart_tx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 867
) (
    input  wire logic        Clk,
    input  wire logic        Rst,
    soc_uart_tx_if.slave     bus,
    output logic             TxD,
    output logic             TxIrq
);

    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_DEPTH   = C_CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]        C_DIV_RST = 16'(DEFAULT_DIV);

    localparam logic [1:0] C_ADDR_TXDATA  = 2'd0;
    localparam logic [1:0] C_ADDR_STATUS  = 2'd1;
    localparam logic [1:0] C_ADDR_BAUDDIV = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [31:0]        rdata_q,    rdata_d;
    logic               ack_q,      ack_d;
    logic [15:0]        baud_div_q, baud_div_d;
    logic               ovf_q,      ovf_d;

    logic [7:0]         fifo_q [FIFO_DEPTH];
    logic [7:0]         fifo_d [FIFO_DEPTH];
    logic [C_PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [C_PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [C_CNT_W-1:0] count_q,    count_d;

    state_t             state_q,    state_d;
    logic [15:0]        timer_q,    timer_d;
    logic [15:0]        div_q,      div_d;
    logic [7:0]         shift_q,    shift_d;
    logic [2:0]         bit_q,      bit_d;
    logic               txd_q,      txd_d;

    logic               w_full;
    logic               w_empty;
    logic               w_busy;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf_set;
    logic               w_ovf_clr;
    logic               w_timer_done;
    logic               w_unused;

    assign w_full       = (count_q == C_DEPTH);
    assign w_empty      = (count_q == '0);
    assign w_busy       = (state_q != ST_IDLE);
    assign w_timer_done = (timer_q == div_q);

    // Upper write-data bits have no register behind them.
    assign w_unused = &{1'b0, bus.BusWData[31:16]};

    assign bus.BusRData = rdata_q;
    assign bus.BusAck   = ack_q;
    assign TxD          = txd_q;
    // Derived from flops only, so the interrupt never sees bus inputs.
    assign TxIrq        = w_empty & ~w_busy;

    // Bus decode: one-cycle registered ack/read data, write side effects
    always_comb begin
        ack_d      = bus.BusEn;
        rdata_d    = '0;
        baud_div_d = baud_div_q;
        w_push     = 1'b0;
        w_ovf_set  = 1'b0;
        w_ovf_clr  = 1'b0;
        if (bus.BusEn) begin
            if (bus.BusWe) begin
                case (bus.BusAddr)
                    C_ADDR_TXDATA: begin
                        // FULL is judged on the current count, ahead of any
                        // pop happening in the same cycle.
                        if (w_full) begin
                            w_ovf_set = 1'b1;
                        end else begin
                            w_push = 1'b1;
                        end
                    end
                    C_ADDR_BAUDDIV: baud_div_d = bus.BusWData[15:0];
                    default: ;
                endcase
            end else begin
                case (bus.BusAddr)
                    C_ADDR_STATUS: begin
                        rdata_d   = {28'd0, ovf_q, w_busy, w_empty, w_full};
                        w_ovf_clr = 1'b1;
                    end
                    C_ADDR_BAUDDIV: rdata_d = {16'd0, baud_div_q};
                    default: ;
                endcase
            end
        end
        // A new overflow outranks a clearing STATUS read.
        if (w_ovf_set) begin
            ovf_d = 1'b1;
        end else if (w_ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Bus-side register update
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            baud_div_q <= C_DIV_RST;
            ovf_q      <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            baud_div_q <= baud_div_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage, pointers and occupancy
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            fifo_d[wr_ptr_q] = bus.BusWData[7:0];
            wr_ptr_d         = wr_ptr_q + C_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_W'(1);
            2'b01:   count_d = count_q - C_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO register update; reset discards all queued bytes
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Frame sequencer: next state, bit timer and shifter control
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        div_d   = div_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        w_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = fifo_q[rd_ptr_q];
                    div_d   = baud_div_q;
                    timer_d = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_timer_done) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (w_timer_done) begin
                    timer_d = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (w_timer_done) begin
                    timer_d = '0;
                    // Chain straight into the next frame with no idle gap.
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        shift_d = fifo_q[rd_ptr_q];
                        div_d   = baud_div_q;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the state being entered so TxD is a clean flop
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // Sequencer register update; async reset forces the line idle at once
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            div_q   <= C_DIV_RST;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soc_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_soc_uart_tx
//  Brief    : Directed self-checking bench for soc_uart_tx.
//  Revision : 1.0  initial release
// ============================================================================
module tb_soc_uart_tx;

    logic Clk;
    logic Rst;
    logic TxD;
    logic TxIrq;

    int n_cmp = 0;
    int n_bad = 0;

    soc_uart_tx_if bus_if ();

    soc_uart_tx #(
        .FIFO_DEPTH  (4),
        .DEFAULT_DIV (867)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .bus   (bus_if.slave),
        .TxD   (TxD),
        .TxIrq (TxIrq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge, well away from the sampling edge.
    task automatic bus_drive(input logic en, input logic we, input logic [1:0] addr,
                             input logic [31:0] data);
        @(negedge Clk);
        bus_if.BusEn    = en;
        bus_if.BusWe    = we;
        bus_if.BusAddr  = addr;
        bus_if.BusWData = data;
    endtask

    task automatic bus_idle();
        bus_drive(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus_drive(1'b1, 1'b1, addr, data);
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp, input string tag);
        bus_drive(1'b1, 1'b0, addr, 32'd0);
        bus_idle();
        check({tag, "_ack"}, {31'd0, bus_if.BusAck}, 32'd1);
        check(tag, bus_if.BusRData, exp);
    endtask

    // Returns at the first falling-edge sample showing the start bit.
    task automatic wait_start(input int max_cyc, input string tag);
        bit found;
        found = (TxD === 1'b0);
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(negedge Clk);
            if (TxD === 1'b0) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    // Walks one 8N1 frame sample by sample. Sample 0 is the current
    // negedge when at_first is set. Optionally rewrites BAUDDIV mid-frame.
    task automatic check_frame(input logic [7:0] data, input int div, input bit at_first,
                               input bit mid_wr, input logic [15:0] mid_val,
                               input string tag);
        logic exp_bit;
        int   nbit;
        for (int k = 0; k < 10 * (div + 1); k++) begin
            if (!(at_first && k == 0)) @(negedge Clk);
            nbit = k / (div + 1);
            if (nbit == 0)      exp_bit = 1'b0;
            else if (nbit == 9) exp_bit = 1'b1;
            else                exp_bit = data[nbit-1];
            check(tag, {31'd0, TxD}, {31'd0, exp_bit});
            if (mid_wr && k == 1) begin
                bus_if.BusEn    = 1'b1;
                bus_if.BusWe    = 1'b1;
                bus_if.BusAddr  = 2'd2;
                bus_if.BusWData = {16'd0, mid_val};
            end
            if (mid_wr && k == 2) begin
                bus_if.BusEn = 1'b0;
                bus_if.BusWe = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst             = 1'b0;
        bus_if.BusEn    = 1'b0;
        bus_if.BusWe    = 1'b0;
        bus_if.BusAddr  = 2'd0;
        bus_if.BusWData = 32'd0;

        // Reset and register defaults
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check("rst_txd",   {31'd0, TxD},   32'd1);
        check("rst_irq",   {31'd0, TxIrq}, 32'd1);
        check("rst_ack",   {31'd0, bus_if.BusAck}, 32'd0);
        check("rst_rdata", bus_if.BusRData, 32'd0);
        bus_read(2'd1, 32'h2,   "rst_status");
        bus_read(2'd2, 32'd867, "rst_bauddiv");
        bus_read(2'd0, 32'd0,   "txdata_read");
        bus_read(2'd3, 32'd0,   "reserved_read");
        @(negedge Clk);
        check("ack_one_cycle", {31'd0, bus_if.BusAck}, 32'd0);
        check("rdata_idle",    bus_if.BusRData, 32'd0);

        // Single frame, 4 clocks per bit
        bus_write(2'd2, 32'hFFFF_0003);
        bus_read(2'd2, 32'd3, "bauddiv_upper_masked");
        bus_write(2'd0, 32'h0000_00A5);
        wait_start(10, "a5_start");
        check_frame(8'hA5, 3, 1'b1, 1'b0, 16'd0, "a5_bit");
        @(negedge Clk);
        check("a5_idle_txd", {31'd0, TxD},   32'd1);
        check("a5_idle_irq", {31'd0, TxIrq}, 32'd1);

        // Two back-to-back frames, 2 clocks per bit, no idle gap
        bus_write(2'd2, 32'd1);
        bus_drive(1'b1, 1'b1, 2'd0, 32'h55);
        bus_drive(1'b1, 1'b1, 2'd0, 32'hAA);
        bus_idle();
        wait_start(10, "b2b_start");
        check_frame(8'h55, 1, 1'b1, 1'b0, 16'd0, "b2b_55_bit");
        check_frame(8'hAA, 1, 1'b0, 1'b0, 16'd0, "b2b_aa_bit");
        bus_read(2'd1, 32'h2, "b2b_status_empty");
        check("b2b_irq", {31'd0, TxIrq}, 32'd1);

        // BAUDDIV changed mid-frame only affects the following frame
        bus_write(2'd2, 32'd3);
        bus_drive(1'b1, 1'b1, 2'd0, 32'h0F);
        bus_drive(1'b1, 1'b1, 2'd0, 32'h3C);
        bus_idle();
        wait_start(10, "div_start");
        check_frame(8'h0F, 3, 1'b1, 1'b1, 16'd7, "div_old_bit");
        check_frame(8'h3C, 7, 1'b0, 1'b0, 16'd0, "div_new_bit");
        @(negedge Clk);
        check("div_idle_txd", {31'd0, TxD}, 32'd1);
        bus_read(2'd2, 32'd7, "div_readback");

        // Overflow: one popped, four queued, sixth dropped
        bus_write(2'd2, 32'd100);
        for (int i = 0; i < 6; i++) begin
            bus_drive(1'b1, 1'b1, 2'd0, 32'h11 * i);
        end
        bus_idle();
        bus_read(2'd1, 32'hD, "ovf_status");
        bus_read(2'd1, 32'h5, "ovf_cleared");
        check("ovf_irq", {31'd0, TxIrq}, 32'd0);

        // Reset in the middle of data bit 0 of byte 0x00
        repeat (150) @(negedge Clk);
        check("mid_data_txd", {31'd0, TxD}, 32'd0);
        #2 Rst = 1'b0;
        #1;
        check("async_rst_txd", {31'd0, TxD},   32'd1);
        check("async_rst_irq", {31'd0, TxIrq}, 32'd1);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        bus_read(2'd1, 32'h2,   "post_rst_status");
        bus_read(2'd2, 32'd867, "post_rst_bauddiv");
        repeat (5) @(negedge Clk);
        check("post_rst_txd", {31'd0, TxD},   32'd1);
        check("post_rst_irq", {31'd0, TxIrq}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
